mult_div_unit: RTL and testbench

Sequential signed multiply/divide unit for the multicycle MIPS datapath, implementing `mult` and `div`. It owns the architectural HI and LO registers. HI and LO feed the register-file write-data select directly, as the `inFromHI` and `inFromLO` sources used by `mfhi` and `mflo`. The control FSM starts an operation with a one-cycle request and stalls on `busy` until `done`.

---
 rtl/mdu_pkg.sv | 13 +
 rtl/mult_div_unit_div_restore_step.sv | 26 ++
 rtl/mult_div_unit.sv | 144 ++++++++++++++
 tb/tb_mult_div_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
package mdu_pkg;
  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITER  = 32;
  localparam int MDU_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } mdu_state_e;
endpackage

// File: rtl/mult_div_unit_div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and emit the quotient bit.
module div_restore_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Trial subtraction; the top bit of diff is the borrow.
  always_comb begin
    shifted  = {rem, dvd_bit};
    diff     = shifted - {2'b00, dsr};
    q_bit    = ~diff[WIDTH+1];
    rem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) unit that
// owns the HI and LO registers.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e state, state_nxt;

  logic [MDU_CNT_W-1:0] cnt;
  // acc_hi: Booth upper product (33b) or partial remainder.
  // acc_lo: multiplier/product low or dividend shifting into quotient.
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             qm1;
  logic [WIDTH-1:0] opd;      // multiplicand, or divisor magnitude
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dvz;
  logic             last_iter;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_rem;
  logic             div_q;

  assign last_iter = (cnt == MDU_CNT_W'(MDU_ITER - 1));
  assign busy      = (state != IDLE);

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem      (acc_hi),
    .dvd_bit  (acc_lo[WIDTH-1]),
    .dsr      (opd),
    .rem_next (div_rem),
    .q_bit    (div_q)
  );

  // Booth add/subtract selection from {q0, q-1}.
  always_comb begin
    m_ext = {opd[WIDTH-1], opd};
    case ({acc_lo[0], qm1})
      2'b01:   booth_sum = acc_hi + m_ext;
      2'b10:   booth_sum = acc_hi - m_ext;
      default: booth_sum = acc_hi;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; multiply wins when both starts arrive together.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_mult)     state_nxt = MULT;
               else if (start_div) state_nxt = DIV;
      MULT:    if (last_iter)      state_nxt = FINISH;
      DIV:     if (dvz || last_iter) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iterations, and the HI/LO write at FINISH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      qm1         <= 1'b0;
      opd         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dvz         <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: if (start_mult || start_div) begin
          cnt    <= '0;
          acc_hi <= '0;
          qm1    <= 1'b0;
          is_div <= ~start_mult;
          neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
          neg_r  <= a[WIDTH-1];
          dvz    <= ~start_mult && (b == '0);
          if (start_mult) begin
            opd    <= a;
            acc_lo <= b;
          end else begin
            opd    <= b[WIDTH-1] ? -b : b;
            acc_lo <= a[WIDTH-1] ? -a : a;
          end
        end
        MULT: begin
          acc_hi <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          acc_lo <= {booth_sum[0], acc_lo[WIDTH-1:1]};
          qm1    <= acc_lo[0];
          cnt    <= cnt + 1'b1;
        end
        DIV: if (!dvz) begin
          acc_hi <= div_rem;
          acc_lo <= {acc_lo[WIDTH-2:0], div_q};
          cnt    <= cnt + 1'b1;
        end
        FINISH: begin
          done        <= 1'b1;
          div_by_zero <= is_div && dvz;
          if (!is_div) begin
            hi <= acc_hi[WIDTH-1:0];
            lo <= acc_lo;
          end else if (!dvz) begin
            hi <= neg_r ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
            lo <= neg_q ? -acc_lo : acc_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + randomized bench for mult_div_unit against a plain-arithmetic
// model of the HI/LO results and the expected done latency.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed 64-bit arithmetic; SV division truncates toward zero.
  task automatic model(input bit is_div, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!is_div) begin
      p = sx * sy;
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (y != 0) begin
      q = sx / sy;
      r = sx % sy;
      m_hi = r[31:0];
      m_lo = q[31:0];
    end
  endtask

  task automatic run_op(input string tag, input bit do_mult, input bit do_div,
                        input logic [31:0] x, input logic [31:0] y, input int inject = 0);
    int n;
    int exp_lat;
    bit busy_ok;
    bit zero_div;
    zero_div = !do_mult && (y == 0);
    exp_lat  = zero_div ? 2 : 33;
    @(negedge clk);
    a = x; b = y; start_mult = do_mult; start_div = do_div;
    @(posedge clk); #1;
    start_mult = 1'b0; start_div = 1'b0;
    a = $urandom; b = $urandom;
    chk({tag, " busy@E0"}, 32'(busy), 32'd1);
    n = 0;
    busy_ok = 1'b1;
    while (n < 40 && !done) begin
      start_div = (inject > 0) && (n + 1 == inject);
      @(posedge clk); #1;
      n++;
      if (!done && !busy) busy_ok = 1'b0;
      if (n == 10) chk({tag, " hi stable"}, hi, m_hi);
    end
    start_div = 1'b0;
    model(!do_mult, x, y);
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " busy held"}, 32'(busy_ok), 32'd1);
    chk({tag, " hi"}, hi, m_hi);
    chk({tag, " lo"}, lo, m_lo);
    chk({tag, " dbz"}, 32'(div_by_zero), 32'(zero_div));
    chk({tag, " busy@done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, " done pulse"}, 32'(done), 32'd0);
    chk({tag, " dbz pulse"}, 32'(div_by_zero), 32'd0);
  endtask

  initial begin
    logic [31:0] x, y;
    bit saw_done;

    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    run_op("mul 7*-3",     1, 0, 32'd7,          32'hFFFFFFFD);
    chk("mul 7*-3 lit hi", hi, 32'hFFFFFFFF);
    chk("mul 7*-3 lit lo", lo, 32'hFFFFFFEB);
    run_op("mul min*min",  1, 0, 32'h80000000,   32'h80000000);
    chk("mul min*min lit hi", hi, 32'h40000000);
    run_op("mul min*-1",   1, 0, 32'h80000000,   32'hFFFFFFFF);
    chk("mul min*-1 lit lo", lo, 32'h80000000);
    run_op("div -7/2",     0, 1, 32'hFFFFFFF9,   32'd2);
    chk("div -7/2 lit lo", lo, 32'hFFFFFFFD);
    chk("div -7/2 lit hi", hi, 32'hFFFFFFFF);
    run_op("div 7/-2",     0, 1, 32'd7,          32'hFFFFFFFE);
    chk("div 7/-2 lit hi", hi, 32'h00000001);
    run_op("div min/-1",   0, 1, 32'h80000000,   32'hFFFFFFFF);
    chk("div min/-1 lit lo", lo, 32'h80000000);
    chk("div min/-1 lit hi", hi, 32'h00000000);
    run_op("preload",      0, 1, 32'h00000451,   32'h00000020);
    chk("preload lit hi", hi, 32'h11);
    chk("preload lit lo", lo, 32'h22);
    run_op("div 5/0",      0, 1, 32'd5,          32'd0);
    chk("div 5/0 lit hi", hi, 32'h11);
    chk("div 5/0 lit lo", lo, 32'h22);
    run_op("mul div@E5",   1, 0, 32'h00012345,   32'hFFFF0F00, 5);
    run_op("both starts",  1, 1, 32'hFFFFFF85,   32'h00000101);

    for (int i = 0; i < 12; i++) begin
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 2) == 0) y = 32'($signed($urandom_range(0, 30)) - 15);
      if ($urandom_range(0, 5) == 0) y = 32'd0;
      if ($urandom_range(0, 1) == 0) run_op("rand mul", 1, 0, x, y);
      else                           run_op("rand div", 0, 1, x, y);
    end

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    a = 32'h7FFF1234; b = 32'h00000033; start_div = 1'b1;
    @(posedge clk); #1;
    start_div = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    chk("mid rst hi", hi, 32'd0);
    chk("mid rst lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk); reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("no done after rst", 32'(saw_done), 32'd0);
    run_op("post rst mul", 1, 0, 32'hFFFFFFF0, 32'h00000009);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
